pipelined_cla_adder: RTL

- Parametrised two-level carry-lookahead adder/subtractor with a 2-stage valid/ready pipeline.
- Successor to the fixed 2-group level-2 lookahead unit. Supports any WIDTH split into WIDTH/GROUP groups, a subtract mode, and ALU status flags.
- Sits between the register-file read ports and ALU writeback for multi-cycle and pipelined datapath variants.

---
 rtl/pipelined_cla_adder_pkg.sv | 18 +
 rtl/cla_group_pg.sv | 31 +++
 rtl/pipelined_cla_adder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared ALU definitions for the carry-lookahead adder and its users.
// Holds default datapath sizing and the bit positions of the status flags
// so that the adder and downstream writeback logic agree on the layout.
package alu_defs;

  localparam int ALU_W     = 32;
  localparam int CLA_GROUP = 4;

  // Status bus bit positions
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int NFLAGS = 4;

  typedef logic [NFLAGS-1:0] flags_t;

endpackage

// File: rtl/cla_group_pg.sv
// First-level lookahead group: per-bit propagate/generate plus the group
// propagate (GP) and group generate (GG) terms. Purely combinational.
//
// Ports:
//   a, bx  in   GROUP  operand bits for this group (bx already inverted for sub)
//   p, g   out  GROUP  per-bit propagate (a^bx) and generate (a&bx)
//   gp     out  1      all bits of the group propagate
//   gg     out  1      the group produces a carry out on its own
module cla_group_pg #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] bx,
  output logic [GROUP-1:0] p,
  output logic [GROUP-1:0] g,
  output logic             gp,
  output logic             gg
);

  always_comb begin
    p  = a ^ bx;
    g  = a & bx;
    gp = &p;
    // Walk from LSB to MSB: gg = g[n-1] | p[n-1]&(g[n-2] | p[n-2]&(...)).
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      gg = g[i] | (p[i] & gg);
    end
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-level carry-lookahead adder/subtractor with a 2-stage valid/ready
// pipeline. Stage 1 registers per-bit and per-group propagate/generate;
// stage 2 resolves group carries, forms the sum and the ALU flags and
// registers them into the output stage.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-low
//   in_valid   in   1      operand beat present
//   in_ready   out  1      beat accepted this cycle
//   a, b       in   WIDTH  operands
//   c_in       in   1      carry-in (ignored when sub=1)
//   sub        in   1      1 = a - b (a + ~b + 1)
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   c_out      out  1      carry out of MSB (for sub: 1 means a >= b unsigned)
//   ovf        out  1      signed overflow
//   zero       out  1      sum == 0
//   neg        out  1      sum MSB
module pipelined_cla_adder
  import alu_defs::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NGRP = (GROUP > 0) ? (WIDTH / GROUP) : 1;

  generate
    if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_param
      $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
    end
  endgenerate

  // Operand prep and first-level lookahead
  logic [WIDTH-1:0] bx;
  logic             cx;
  logic [WIDTH-1:0] p_d, g_d;
  logic [NGRP-1:0]  gp_d, gg_d;

  assign bx = sub ? ~b : b;
  assign cx = sub | c_in;

  generate
    for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_group_pg #(.GROUP(GROUP)) u_pg (
        .a  (a [k*GROUP +: GROUP]),
        .bx (bx[k*GROUP +: GROUP]),
        .p  (p_d[k*GROUP +: GROUP]),
        .g  (g_d[k*GROUP +: GROUP]),
        .gp (gp_d[k]),
        .gg (gg_d[k])
      );
    end
  endgenerate

  // Handshake
  logic s1_valid;
  logic adv1, adv2;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // Stage 1 registers
  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NGRP-1:0]  s1_gp, s1_gg;
  logic             s1_cx;
  logic             s1_a_msb, s1_bx_msb;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
    end
  end

  // Payload needs no reset: it is only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      s1_p      <= p_d;
      s1_g      <= g_d;
      s1_gp     <= gp_d;
      s1_gg     <= gg_d;
      s1_cx     <= cx;
      s1_a_msb  <= a[WIDTH-1];
      s1_bx_msb <= bx[WIDTH-1];
    end
  end

  // Stage 2: group carry chain, intra-group carries, sum and flags
  logic [WIDTH-1:0] cin_bit;
  logic [WIDTH-1:0] sum_d;
  logic             c_grp, c_run;
  flags_t           flags_d;

  always_comb begin
    cin_bit = '0;
    c_grp   = s1_cx;
    c_run   = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      c_run = c_grp;
      for (int j = 0; j < GROUP; j++) begin
        cin_bit[k*GROUP + j] = c_run;
        c_run = s1_g[k*GROUP + j] | (s1_p[k*GROUP + j] & c_run);
      end
      // Next group's carry comes from the lookahead terms, not the ripple.
      c_grp = s1_gg[k] | (s1_gp[k] & c_grp);
    end
    sum_d = s1_p ^ cin_bit;

    flags_d         = '0;
    flags_d[FLAG_C] = c_grp;
    // Same result as carry-into-MSB ^ carry-out: like-signed operands
    // producing a result of the opposite sign.
    flags_d[FLAG_V] = (s1_a_msb == s1_bx_msb) && (sum_d[WIDTH-1] != s1_a_msb);
    flags_d[FLAG_Z] = ~|sum_d;
    flags_d[FLAG_N] = sum_d[WIDTH-1];
  end

  // Output registers
  flags_t flags_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      flags_q   <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum     <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign c_out = flags_q[FLAG_C];
  assign ovf   = flags_q[FLAG_V];
  assign zero  = flags_q[FLAG_Z];
  assign neg   = flags_q[FLAG_N];

endmodule
